weighted_rr_scheduler: RTL
==========================

Name: weighted_rr_scheduler

Overview:
- Shares one downstream beat channel among NumReq requesters using packet-granular weighted round-robin.
- Each granted requester keeps the channel for up to its weight in complete packets. The grant is then released and passed on in rotating priority order.
- Sits between the requester mux and the shared datapath. It is a stateful, packet-aware companion to the plain round_robin_arbiter.

Parameters:
- Clog2NumReq, 2, log2 of the requester count.
- NumReq, 2**Clog2NumReq, requester count (derived; not overridden).
- WeightWidth, 4, width of each per-requester weight and of the internal credit counter.

Ports:
- clk_i  input  1  clock; all logic is on the rising edge.
- rst_i  input  1  synchronous, active-high reset.
- req_i  input  NumReq  per-requester request, level-sensitive.
- weight_i  input  NumReq*WeightWidth  packed weights; requester k occupies bits [k*WeightWidth +: WeightWidth].
- last_i  input  NumReq  per-requester end-of-packet flag for the current beat.
- ready_i  input  1  downstream accepts the current beat.
- gnt_o  output  NumReq  registered one-hot grant; all zeros when idle.
- gnt_idx_o  output  Clog2NumReq  index of the granted requester; holds its last value when idle.
- gnt_valid_o  output  1  equals OR of gnt_o.
- credit_o  output  WeightWidth  packets remaining for the current grant; 0 when idle.

Behaviour:
- Reset (rst_i=1 at an edge):
  - State goes to ARB; gnt_o=0, gnt_idx_o=0, gnt_valid_o=0, credit_o=0.
  - Priority pointer ptr=0; mid_pkt=0.
  - Reset overrides every other event in the same cycle, including mid-packet.
- States are ARB and GRANT.
- ARB:
  - Combinationally search req_i starting at index ptr and wrapping modulo NumReq; the first set bit wins.
  - If any request is present, at the next edge:
    - gnt_o=onehot(winner), gnt_idx_o=winner.
    - credit = weight_i[winner], with 0 loaded as 1.
    - State goes to GRANT.
  - If no request is present, remain in ARB with outputs unchanged.
  - Latency from a request arriving in ARB to the grant is 1 cycle.
- Beat definition: beat = (state==GRANT) & req_i[gnt_idx_o] & ready_i.
- Packet end: pkt_end = beat & last_i[gnt_idx_o].
- mid_pkt:
  - Set on a beat with last=0.
  - Cleared on pkt_end.
- On pkt_end, credit decrements by 1. The counter never underflows.
- Release from GRANT, at the next edge:
  - gnt_o=0, credit_o=0, mid_pkt=0.
  - ptr = (gnt_idx_o+1) mod NumReq, wrapping from NumReq-1 to 0.
  - State goes to ARB.
- A release occurs when either:
  - (a) pkt_end with credit==1, or
  - (b) req_i[gnt_idx_o]=0 while mid_pkt=0 and no beat is in progress.
- Dropping req_i mid-packet (mid_pkt=1) does not release; the grant holds until the packet completes.
- Each release is followed by exactly one cycle with gnt_valid_o=0 (the ARB cycle). There is no back-to-back grant change.
- ready_i=0: no beat occurs, and credit and mid_pkt hold.
- Weight changes on weight_i while in GRANT have no effect; the weight is sampled only at grant.
- A released requester that is still requesting competes again at lowest priority behind the others.
- Invariants checked by assertion:
  - gnt_o is one-hot or zero at all times.
  - gnt_valid_o == |gnt_o.
  - credit_o is never 0 while in GRANT.

Test Plan (NumReq=4, WeightWidth=4, ready_i=1 unless noted):
- Reset:
  - Stimulus: rst_i=1 for 2 cycles with req_i=4'hF.
  - Required: gnt_o=0, credit_o=0, gnt_idx_o=0 throughout.
  - After release with req_i=4'hF, the first grant is gnt_o=4'b0001 exactly 1 cycle after the first cycle with rst_i=0.
- Weighted hold:
  - Stimulus: req_i=4'b0100, weight2=2, packets of 3 beats (last on beat 3).
  - Required: gnt_o=4'b0100 one cycle after request; credit_o goes 2→1 after the first packet.
  - Release after beat 6; the next cycle shows gnt_o=0, then gnt_o=4'b0100 again.
- Rotation:
  - Stimulus: req_i=4'hF, all weights 1, single-beat packets (last_i=4'hF).
  - Required: gnt_idx_o sequence 0,1,2,3,0, with one idle cycle between each grant.
  - Also: weight 0 on requester 1 behaves identically to weight 1.
- Backpressure:
  - Stimulus: mid-packet under grant of requester 3, ready_i=0 for 5 cycles.
  - Required: gnt_o stays 4'b1000, credit_o unchanged.
  - The packet completes on the first beat after ready_i returns to 1.
- Request drop:
  - Stimulus: requester 1 deasserts req_i between packets with credit 3.
  - Required: release on the next edge, with ptr advancing so requester 2 wins.
  - Stimulus: requester 1 deasserts mid-packet.
  - Required: gnt_o stays 4'b0010 until pkt_end.
- Reset mid-grant:
  - Stimulus: rst_i=1 for 1 cycle during GRANT of requester 2 with mid_pkt=1.
  - Required: the next cycle shows gnt_o=0, credit_o=0, ptr=0.
  - With req_i=4'b0110, the next grant goes to requester 1.

Source files
------------

// File: rtl/weighted_rr_scheduler.sv
// Packet-granular weighted round-robin scheduler: a granted requester keeps the
// shared beat channel for up to its weight in complete packets, then rotates.
module weighted_rr_scheduler #(
  parameter int unsigned Clog2NumReq = 2,
  parameter int unsigned WeightWidth = 4
) (
  input  logic                            clk_i,
  input  logic                            rst_i,
  input  logic [(1<<Clog2NumReq)-1:0]     req_i,
  input  logic [(1<<Clog2NumReq)*WeightWidth-1:0] weight_i,
  input  logic [(1<<Clog2NumReq)-1:0]     last_i,
  input  logic                            ready_i,
  output logic [(1<<Clog2NumReq)-1:0]     gnt_o,
  output logic [Clog2NumReq-1:0]          gnt_idx_o,
  output logic                            gnt_valid_o,
  output logic [WeightWidth-1:0]          credit_o
);

  localparam int unsigned NumReq = 1 << Clog2NumReq;

  typedef enum logic {
    ST_ARB,
    ST_GRANT
  } state_e;

  state_e                   state_q, state_d;
  logic [NumReq-1:0]        gnt_q, gnt_d;
  logic [Clog2NumReq-1:0]   idx_q, idx_d;
  logic [Clog2NumReq-1:0]   ptr_q, ptr_d;
  logic [WeightWidth-1:0]   credit_q, credit_d;
  logic                     valid_q, valid_d;
  logic                     mid_q, mid_d;

  logic                     found;
  logic [Clog2NumReq-1:0]   win;
  logic [Clog2NumReq-1:0]   cand;
  logic [WeightWidth-1:0]   win_weight;
  logic                     beat;
  logic                     pkt_end;
  logic                     release_now;

  // Rotating-priority search starting at ptr; index arithmetic wraps naturally.
  always_comb begin
    found = 1'b0;
    win   = '0;
    cand  = '0;
    for (int unsigned i = 0; i < NumReq; i++) begin
      cand = ptr_q + Clog2NumReq'(i);
      if (!found && req_i[cand]) begin
        found = 1'b1;
        win   = cand;
      end
    end
    win_weight = weight_i[win*WeightWidth +: WeightWidth];
  end

  assign beat        = (state_q == ST_GRANT) & req_i[idx_q] & ready_i;
  assign pkt_end     = beat & last_i[idx_q];
  // Release on last credited packet, or on an idle requester between packets.
  assign release_now = (pkt_end && (credit_q == WeightWidth'(1))) ||
                       (!req_i[idx_q] && !mid_q);

  always_comb begin
    state_d  = state_q;
    gnt_d    = gnt_q;
    idx_d    = idx_q;
    ptr_d    = ptr_q;
    credit_d = credit_q;
    valid_d  = valid_q;
    mid_d    = mid_q;
    unique case (state_q)
      ST_ARB: begin
        if (found) begin
          gnt_d    = NumReq'(1) << win;
          idx_d    = win;
          credit_d = (win_weight == '0) ? WeightWidth'(1) : win_weight;
          valid_d  = 1'b1;
          state_d  = ST_GRANT;
        end
      end
      ST_GRANT: begin
        if (release_now) begin
          gnt_d    = '0;
          valid_d  = 1'b0;
          credit_d = '0;
          mid_d    = 1'b0;
          ptr_d    = idx_q + Clog2NumReq'(1);
          state_d  = ST_ARB;
        end else if (pkt_end) begin
          mid_d = 1'b0;
          if (credit_q > WeightWidth'(1)) credit_d = credit_q - WeightWidth'(1);
        end else if (beat) begin
          mid_d = 1'b1;
        end
      end
      default: state_d = ST_ARB;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q  <= ST_ARB;
      gnt_q    <= '0;
      idx_q    <= '0;
      ptr_q    <= '0;
      credit_q <= '0;
      valid_q  <= 1'b0;
      mid_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      gnt_q    <= gnt_d;
      idx_q    <= idx_d;
      ptr_q    <= ptr_d;
      credit_q <= credit_d;
      valid_q  <= valid_d;
      mid_q    <= mid_d;
    end
  end

  assign gnt_o       = gnt_q;
  assign gnt_idx_o   = idx_q;
  assign gnt_valid_o = valid_q;
  assign credit_o    = credit_q;

  a_gnt_onehot0: assert property (@(posedge clk_i) disable iff (rst_i) $onehot0(gnt_q));
  a_gnt_valid:   assert property (@(posedge clk_i) disable iff (rst_i) valid_q == (|gnt_q));
  a_credit_nz:   assert property (@(posedge clk_i) disable iff (rst_i)
                                  (state_q == ST_GRANT) |-> (credit_q != '0));

endmodule
